pic_priority_isr: RTL

Downstream stage of the 8259 interrupt request register: resolves priority among the pending, unmasked requests, raises INT to the CPU, and runs the two-pulse 8086 INTA sequence. During that sequence it drives the one-hot `clear_IRR` and `freeze` signals back into the IRR, holds the In-Service Register (ISR), and supplies the interrupt vector. It also services EOI commands from the control logic.

---
 rtl/pic_priority_isr.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pic_priority_isr.sv
// 8259 priority resolver, ISR and INTA sequencer.
// Fixed priority, fully nested; drives IRR clear/freeze and the vector.
module pic_priority_isr #(
  parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] IRR_Output,
  input  logic [7:0] IMR,
  input  logic       inta_n,
  input  logic       aeoi,
  input  logic       eoi_ns,
  input  logic       eoi_sp,
  input  logic [2:0] eoi_level,
  input  logic [4:0] vector_base,
  output logic       int_out,
  output logic [7:0] clear_IRR,
  output logic       freeze,
  output logic [7:0] ISR,
  output logic [7:0] vector_out,
  output logic       vector_oe
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT1,
    S_ACK1,
    S_WAIT2,
    S_ACK2
  } state_t;

  state_t     r_state;
  state_t     w_state_n;
  logic       r_inta_q;
  logic [2:0] r_lvl;
  logic       r_spur;
  logic [7:0] w_pend;
  logic [2:0] w_req_lvl;
  logic [3:0] w_isr_lvl;
  logic       w_cond;
  logic       w_fall;
  logic       w_rise;
  logic [7:0] w_set;
  logic [7:0] w_clr;
  logic       w_int_n;

  assign w_pend = IRR_Output & ~IMR;
  assign w_fall = r_inta_q & ~inta_n;
  assign w_rise = ~r_inta_q & inta_n;

  // Lowest set index of pending requests and of the ISR (8 = empty).
  always_comb begin
    w_req_lvl = 3'd0;
    w_isr_lvl = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (w_pend[i]) w_req_lvl = 3'(i);
      if (ISR[i])    w_isr_lvl = 4'(i);
    end
  end

  assign w_cond = (w_pend != 8'h00) && ({1'b0, w_req_lvl} < w_isr_lvl);

  // Next state and next int_out.
  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      S_IDLE:  if (w_fall) w_state_n = S_ACK1;
               else if (w_cond) w_state_n = S_WAIT1;
      S_WAIT1: if (w_fall) w_state_n = S_ACK1;
               else if (!w_cond) w_state_n = S_IDLE;
      S_ACK1:  if (w_rise) w_state_n = S_WAIT2;
      S_WAIT2: if (w_fall) w_state_n = S_ACK2;
      S_ACK2:  if (w_rise) w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
    w_int_n = 1'b0;
    unique case (w_state_n)
      S_IDLE, S_WAIT1: w_int_n = w_cond;
      S_ACK1:          w_int_n = int_out;
      default:         w_int_n = 1'b0;
    endcase
  end

  // ISR set/clear masks; EOI decodes the pre-update ISR.
  always_comb begin
    w_set = 8'h00;
    w_clr = 8'h00;
    if ((r_state == S_IDLE || r_state == S_WAIT1) && w_fall && w_cond)
      w_set = 8'h01 << w_req_lvl;
    if (eoi_sp)
      w_clr = 8'h01 << eoi_level;
    else if (eoi_ns && w_isr_lvl != 4'd8)
      w_clr = 8'h01 << w_isr_lvl[2:0];
    if (r_state == S_ACK2 && w_rise && aeoi && !r_spur)
      w_clr = w_clr | (8'h01 << r_lvl);
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_inta_q   <= 1'b1;
      r_lvl      <= 3'd0;
      r_spur     <= 1'b0;
      int_out    <= 1'b0;
      clear_IRR  <= 8'h00;
      freeze     <= 1'b0;
      ISR        <= 8'h00;
      vector_out <= 8'h00;
      vector_oe  <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_inta_q  <= inta_n;
      int_out   <= w_int_n;
      clear_IRR <= w_set;
      ISR       <= (ISR & ~w_clr) | w_set;
      if ((r_state == S_IDLE || r_state == S_WAIT1) && w_fall) begin
        r_lvl  <= w_cond ? w_req_lvl : SPURIOUS_LEVEL;
        r_spur <= ~w_cond;
        freeze <= 1'b1;
      end
      if (r_state == S_WAIT2 && w_fall) begin
        vector_out <= {vector_base, r_lvl};
        vector_oe  <= 1'b1;
      end
      if (r_state == S_ACK2 && w_rise) begin
        vector_oe <= 1'b0;
        freeze    <= 1'b0;
      end
    end
  end

endmodule
